// File: rtl/timing_pkg.sv
// Shared types, widths and helpers for the dt-tick scheduling slice.
package timing_pkg;

    localparam int unsigned THETA_W = 12;
    localparam int unsigned DTICK_W = 16;
    localparam int unsigned FREQ_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_ERROR
    } state_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for 0 and 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, dt_ticks} entries.
module tick_fifo
    import timing_pkg::*;
#(
    parameter  int unsigned WIDTH = DTICK_W + 1,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = count[AW];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Head is masked while empty so stale storage never reaches the outputs.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset, reads are masked until an entry exists.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; flush empties without touching storage.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dt_tick_scheduler.sv
// Frame sequencer for the cordic dt-tick chain: issues one column request at a
// time, collects results into an output FIFO, handles abort and timeouts.
module dt_tick_scheduler
    import timing_pkg::*;
#(
    parameter int unsigned FRAME_COLUMNS_P = 360,
    parameter int unsigned FIFO_DEPTH_P    = 8,
    parameter int unsigned TIMEOUT_P       = 255
) (
    input  logic               clk_i,
    input  logic               nrst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [FREQ_W-1:0]  freq_i,
    output logic [FREQ_W-1:0]  freq_o,
    output logic               theta_iteration_valid_o,
    output logic [THETA_W-1:0] theta_iteration_o,
    input  logic               dt_ticks_valid_i,
    input  logic [DTICK_W-1:0] dt_ticks_i,
    output logic               tick_valid_o,
    input  logic               tick_ready_i,
    output logic [DTICK_W-1:0] tick_o,
    output logic               tick_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);

    localparam int unsigned CW = clog2(FIFO_DEPTH_P) + 1;
    localparam logic [THETA_W-1:0] LAST_COL = THETA_W'(FRAME_COLUMNS_P - 1);

    state_t             state;
    state_t             state_nx;
    logic [THETA_W-1:0] col;
    logic [15:0]        wdog;
    logic [FREQ_W-1:0]  freq_q;
    logic               timeout_q;
    logic               done_q;

    logic               start_ok;
    logic               is_last;
    logic               space;
    logic               wdog_exp;
    logic               strobe;
    logic               push;
    logic               fin;
    logic               to_set;

    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic [DTICK_W:0]   fifo_dout;

    assign start_ok = start_i && (state == ST_IDLE || state == ST_ERROR);
    assign is_last  = (col == LAST_COL);
    assign space    = (fifo_count < CW'(FIFO_DEPTH_P));
    // The issue cycle and the current cycle both count toward the limit, so
    // the error lands TIMEOUT_P cycles after the request strobe.
    assign wdog_exp = (({1'b0, wdog} + 17'd2) >= 17'(TIMEOUT_P));

    // Next-state and per-cycle strobes; abort outranks a same-cycle result.
    always_comb begin
        state_nx = state;
        strobe   = 1'b0;
        push     = 1'b0;
        fin      = 1'b0;
        to_set   = 1'b0;
        unique case (state)
            ST_IDLE, ST_ERROR: begin
                if (start_i) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    state_nx = ST_IDLE;
                end else if (space) begin
                    strobe   = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_nx = dt_ticks_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (dt_ticks_valid_i) begin
                    push = 1'b1;
                    if (is_last) begin
                        fin      = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_ISSUE;
                    end
                end else if (wdog_exp) begin
                    to_set   = 1'b1;
                    state_nx = ST_ERROR;
                end
            end
            ST_DRAIN: begin
                if (dt_ticks_valid_i || wdog_exp) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, column, watchdog and latched outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state     <= ST_IDLE;
            col       <= '0;
            wdog      <= '0;
            freq_q    <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= fin;
            if (start_ok) begin
                freq_q    <= freq_i;
                col       <= '0;
                timeout_q <= 1'b0;
            end
            if (strobe) begin
                wdog <= '0;
            end else if ((state == ST_WAIT || state == ST_DRAIN) && wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
            if (push && !is_last) col <= col + 1'b1;
            if (to_set) timeout_q <= 1'b1;
        end
    end

    tick_fifo #(
        .WIDTH (DTICK_W + 1),
        .DEPTH (FIFO_DEPTH_P)
    ) u_fifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .flush  (start_ok),
        .push   (push && !fifo_full),
        .din    ({is_last, dt_ticks_i}),
        .pop    (tick_ready_i),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign freq_o                  = freq_q;
    assign theta_iteration_valid_o = strobe;
    assign theta_iteration_o       = col;
    assign tick_valid_o            = !fifo_empty;
    assign tick_o                  = fifo_dout[DTICK_W-1:0];
    assign tick_last_o             = fifo_dout[DTICK_W];
    assign busy_o                  = (state != ST_IDLE) && (state != ST_ERROR);
    assign done_o                  = done_q;
    assign timeout_o               = timeout_q;

endmodule

// File: tb/tb_dt_tick_scheduler.sv
// Directed bench: instance A (4 columns, depth 8, timeout 64) and
// instance B (5 columns, depth 2, timeout 10) with a cordic latency model.
module tb_dt_tick_scheduler;

    logic clk;
    logic nrst;

    logic        a_start, a_abort, a_dtv, a_ready;
    logic [23:0] a_freq, a_freq_o;
    logic [15:0] a_dt, a_tk;
    logic [11:0] a_theta;
    logic        a_tv, a_tkv, a_tlast, a_busy, a_done, a_timeout;

    logic        b_start, b_abort, b_dtv, b_ready;
    logic [23:0] b_freq, b_freq_o;
    logic [15:0] b_dt, b_tk;
    logic [11:0] b_theta;
    logic        b_tv, b_tkv, b_tlast, b_busy, b_done, b_timeout;

    dt_tick_scheduler #(
        .FRAME_COLUMNS_P (4),
        .FIFO_DEPTH_P    (8),
        .TIMEOUT_P       (64)
    ) dut_a (
        .clk_i                   (clk),
        .nrst_i                  (nrst),
        .start_i                 (a_start),
        .abort_i                 (a_abort),
        .freq_i                  (a_freq),
        .freq_o                  (a_freq_o),
        .theta_iteration_valid_o (a_tv),
        .theta_iteration_o       (a_theta),
        .dt_ticks_valid_i        (a_dtv),
        .dt_ticks_i              (a_dt),
        .tick_valid_o            (a_tkv),
        .tick_ready_i            (a_ready),
        .tick_o                  (a_tk),
        .tick_last_o             (a_tlast),
        .busy_o                  (a_busy),
        .done_o                  (a_done),
        .timeout_o               (a_timeout)
    );

    dt_tick_scheduler #(
        .FRAME_COLUMNS_P (5),
        .FIFO_DEPTH_P    (2),
        .TIMEOUT_P       (10)
    ) dut_b (
        .clk_i                   (clk),
        .nrst_i                  (nrst),
        .start_i                 (b_start),
        .abort_i                 (b_abort),
        .freq_i                  (b_freq),
        .freq_o                  (b_freq_o),
        .theta_iteration_valid_o (b_tv),
        .theta_iteration_o       (b_theta),
        .dt_ticks_valid_i        (b_dtv),
        .dt_ticks_i              (b_dt),
        .tick_valid_o            (b_tkv),
        .tick_ready_i            (b_ready),
        .tick_o                  (b_tk),
        .tick_last_o             (b_tlast),
        .busy_o                  (b_busy),
        .done_o                  (b_done),
        .timeout_o               (b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Cordic latency models and observation logs per instance.
    int          a_lat, a_cnt, a_quota, a_base, a_done_n, a_freq_bad, a_str_cyc;
    logic [11:0] a_rcol;
    logic [23:0] a_freq_exp;
    int          a_str_q[$];
    int          a_pop_q[$];
    int          b_lat, b_cnt, b_quota, b_base, b_done_n, b_str_cyc;
    logic [11:0] b_rcol;
    int          b_str_q[$];
    int          b_pop_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: log what the DUTs present before the edge, then advance and
    // let the latency models decide the result strobes for the next cycle.
    task automatic step();
        if (a_done) a_done_n++;
        if (a_busy && a_freq_o != a_freq_exp) a_freq_bad++;
        if (a_tkv && a_ready) a_pop_q.push_back(int'({a_tlast, a_tk}));
        if (a_tv) begin
            a_str_q.push_back(int'(a_theta));
            a_rcol = a_theta; a_cnt = a_lat; a_str_cyc = cyc;
        end
        if (b_done) b_done_n++;
        if (b_tkv && b_ready) b_pop_q.push_back(int'({b_tlast, b_tk}));
        if (b_tv) begin
            b_str_q.push_back(int'(b_theta));
            b_rcol = b_theta; b_cnt = b_lat; b_str_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        a_start = 1'b0; a_abort = 1'b0; a_dtv = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_dtv = 1'b0;
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0 && a_quota > 0) begin
                a_quota--; a_dtv = 1'b1; a_dt = 16'(a_base + int'(a_rcol));
            end
        end
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0 && b_quota > 0) begin
                b_quota--; b_dtv = 1'b1; b_dt = 16'(b_base + int'(b_rcol));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        nrst = 1'b0;
        a_start = 0; a_abort = 0; a_dtv = 0; a_ready = 0; a_freq = '0; a_dt = '0;
        b_start = 0; b_abort = 0; b_dtv = 0; b_ready = 0; b_freq = '0; b_dt = '0;
        a_lat = 20; a_cnt = 0; a_quota = 0; a_base = 100; a_done_n = 0; a_freq_bad = 0;
        a_str_cyc = 0; a_rcol = '0; a_freq_exp = '0;
        b_lat = 3; b_cnt = 0; b_quota = 0; b_base = 100; b_done_n = 0; b_str_cyc = 0; b_rcol = '0;

        // Reset values
        #3;
        check("rst_busy", a_busy, 0);
        check("rst_freq", a_freq_o, 0);
        check("rst_tkv", a_tkv, 0);
        check("rst_tv", a_tv, 0);
        check("rst_timeout", b_timeout, 0);
        check("rst_done", b_done, 0);
        #4 nrst = 1'b1;
        step();

        // Full frame, normal flow on A
        a_ready = 1; a_lat = 20; a_quota = 4; a_base = 100;
        a_freq = 24'd21000; a_freq_exp = 24'd21000; a_start = 1;
        step();
        for (int i = 0; i < 400 && a_done_n == 0; i++) step();
        steps(3);
        check("ff_done_n", a_done_n, 1);
        check("ff_nstrobe", a_str_q.size(), 4);
        for (int i = 0; i < a_str_q.size(); i++) check($sformatf("ff_idx%0d", i), a_str_q[i], i);
        check("ff_npop", a_pop_q.size(), 4);
        for (int i = 0; i < a_pop_q.size(); i++)
            check($sformatf("ff_tick%0d", i), a_pop_q[i], (i == 3 ? 32'h10000 : 0) + 100 + i);
        check("ff_freq", a_freq_o, 21000);
        check("ff_freq_stable", a_freq_bad, 0);
        check("ff_busy", a_busy, 0);

        // Back-pressure on B
        b_ready = 0; b_lat = 3; b_quota = 5; b_base = 100; b_freq = 24'd7; b_start = 1;
        step();
        steps(1000);
        check("bp_nstrobe", b_str_q.size(), 2);
        check("bp_busy", b_busy, 1);
        check("bp_timeout", b_timeout, 0);
        check("bp_head", b_tk, 100);
        b_ready = 1;
        for (int i = 0; i < 300 && b_done_n == 0; i++) step();
        steps(3);
        check("bp_nstrobe_all", b_str_q.size(), 5);
        for (int i = 0; i < b_str_q.size(); i++) check($sformatf("bp_idx%0d", i), b_str_q[i], i);
        check("bp_npop", b_pop_q.size(), 5);
        for (int i = 0; i < b_pop_q.size(); i++)
            check($sformatf("bp_tick%0d", i), b_pop_q[i], (i == 4 ? 32'h10000 : 0) + 100 + i);

        // Timeout on B: column 2 never answered
        b_str_q.delete(); b_pop_q.delete(); b_done_n = 0;
        b_quota = 2; b_freq = 24'd9; b_start = 1;
        step();
        begin
            int tcyc;
            tcyc = -1;
            for (int i = 0; i < 200 && tcyc < 0; i++) begin
                step();
                if (b_timeout) tcyc = cyc;
            end
            check("to_seen", (tcyc >= 0), 1);
            check("to_latency", tcyc - b_str_cyc, 10);
        end
        check("to_idx", b_str_q.size() == 3 ? b_str_q[2] : -1, 2);
        check("to_busy", b_busy, 0);
        check("to_no_done", b_done_n, 0);
        b_str_q.delete(); b_quota = 5; b_start = 1;
        step();
        check("to_clear", b_timeout, 0);
        check("to_rst_busy", b_busy, 1);
        for (int i = 0; i < 20 && b_str_q.size() == 0; i++) step();
        check("to_restart_idx", b_str_q.size() > 0 ? b_str_q[0] : -1, 0);
        for (int i = 0; i < 300 && b_done_n == 0; i++) step();
        check("to_restart_done", b_done_n, 1);

        // Abort in WAIT on A: late result must be discarded
        a_ready = 0; a_str_q.delete(); a_pop_q.delete(); a_done_n = 0;
        a_lat = 20; a_quota = 2; a_base = 100; a_freq = 24'd5; a_freq_exp = 24'd5; a_start = 1;
        step();
        for (int i = 0; i < 300 && a_str_q.size() < 3; i++) step();
        check("ab_nstrobe", a_str_q.size(), 3);
        steps(4);
        a_abort = 1;
        steps(15);
        check("ab_draining", a_busy, 1);
        a_dtv = 1; a_dt = 16'd555;
        step();
        check("ab_idle", a_busy, 0);
        check("ab_no_done", a_done_n, 0);
        a_ready = 1;
        steps(2);
        a_ready = 0;
        check("ab_empty", a_tkv, 0);
        check("ab_npop", a_pop_q.size(), 2);
        for (int i = 0; i < a_pop_q.size(); i++) check($sformatf("ab_tick%0d", i), a_pop_q[i], 100 + i);

        // New frame, then abort together with a result on A
        a_str_q.delete(); a_pop_q.delete();
        a_quota = 1; a_base = 200; a_start = 1;
        step();
        for (int i = 0; i < 300 && a_str_q.size() < 2; i++) step();
        check("ar_first_idx", a_str_q.size() > 0 ? a_str_q[0] : -1, 0);
        check("ar_head", a_tk, 200);
        steps(2);
        a_abort = 1; a_dtv = 1; a_dt = 16'd777;
        step();
        check("ar_idle", a_busy, 0);
        check("ar_no_done", a_done_n, 0);
        a_ready = 1;
        steps(3);
        a_ready = 0;
        check("ar_npop", a_pop_q.size(), 1);
        check("ar_tick", a_pop_q.size() > 0 ? a_pop_q[0] : -1, 200);
        check("ar_empty", a_tkv, 0);

        // Reset in WAIT with three entries queued on A
        a_str_q.delete(); a_pop_q.delete();
        a_lat = 5; a_quota = 3; a_base = 300; a_freq = 24'd33; a_freq_exp = 24'd33; a_start = 1;
        step();
        for (int i = 0; i < 200 && a_str_q.size() < 4; i++) step();
        check("rm_nstrobe", a_str_q.size(), 4);
        check("rm_pre_tkv", a_tkv, 1);
        #2 nrst = 1'b0;
        #1;
        check("rm_busy", a_busy, 0);
        check("rm_tkv", a_tkv, 0);
        check("rm_tick", a_tk, 0);
        check("rm_freq", a_freq_o, 0);
        check("rm_tv", a_tv, 0);
        a_dtv = 1; a_dt = 16'd999;
        step();
        nrst = 1'b1;
        a_dtv = 1; a_dt = 16'd999;
        step();
        check("rm_post_tkv", a_tkv, 0);
        check("rm_post_busy", a_busy, 0);
        step();
        check("rm_post_tkv2", a_tkv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
